// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the codec configuration sequencer: FSM encoding,
// default volume sub-address and the default codec init table.
package codec_cfg_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_VISSUE = 3'd4;
  localparam logic [2:0] ST_VWAIT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ISSUE  = ST_ISSUE,
    S_WAIT   = ST_WAIT,
    S_DONE   = ST_DONE,
    S_VISSUE = ST_VISSUE,
    S_VWAIT  = ST_VWAIT
  } state_e;

  localparam logic [7:0] DEFAULT_VOL_ADDR = 8'h02;

  // Default table entries are packed as {addr[7:0], data[15:0]}.
  localparam int ENTRY_ADDR_W = 8;
  localparam int ENTRY_DATA_W = 16;
  localparam int ENTRY_W      = ENTRY_ADDR_W + ENTRY_DATA_W;

  // Default codec bring-up: reset, deactivate, line-in, headphone, path,
  // digital path, power, format, sampling, then activate last.
  function automatic logic [ENTRY_W-1:0] codec_cfg_entry(input logic [31:0] idx);
    case (idx)
      32'd0:   return 24'h0F_0000;
      32'd1:   return 24'h09_0000;
      32'd2:   return 24'h00_0017;
      32'd3:   return 24'h01_0017;
      32'd4:   return 24'h02_0079;
      32'd5:   return 24'h03_0079;
      32'd6:   return 24'h04_0012;
      32'd7:   return 24'h05_0000;
      32'd8:   return 24'h06_0000;
      32'd9:   return 24'h07_0042;
      32'd10:  return 24'h08_0000;
      32'd11:  return 24'h09_0001;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational init-table lookup: entry index -> {sub-address, data}.
// Boards with a different codec swap this file and leave the FSM alone.
module codec_cfg_rom
  import codec_cfg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] sub_addr,
  output logic [DATA_W-1:0] data
);

  logic [ENTRY_W-1:0] entry;

  // Look up the packed entry and resize its fields to the port widths.
  always_comb begin
    entry    = codec_cfg_entry(32'(idx));
    sub_addr = ADDR_W'(entry[ENTRY_W-1 -: ENTRY_ADDR_W]);
    data     = DATA_W'(entry[ENTRY_DATA_W-1:0]);
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Walks the codec init table one write per entry, advancing on the serial
// link's NewCom pulse, with per-entry timeout/retry, sticky done/err,
// software restart and a post-init volume-update command.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 16,
  parameter int                N_ENTRIES  = 12,
  parameter int                TIMEOUT    = 4096,
  parameter int                MAX_RETRY  = 3,
  parameter logic [ADDR_W-1:0] VOL_ADDR   = ADDR_W'(DEFAULT_VOL_ADDR),
  parameter bit                AUTO_START = 1'b1,
  localparam int               IDX_W      = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                NewCom,
  input  logic                vol_req,
  input  logic [DATA_W/2-1:0] vol_left,
  input  logic [DATA_W/2-1:0] vol_right,
  output logic [ADDR_W-1:0]   SubAddr,
  output logic [DATA_W-1:0]   data,
  output logic                write,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W-1:0]    index
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e             state, state_n;
  logic [IDX_W-1:0]   idx_n;
  logic [RTY_W-1:0]   retry, retry_n;
  logic [TMR_W-1:0]   timer;
  logic               done_n, err_n;
  logic               vol_pending;
  logic               timed_out;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;

  // The table is addressed with the next index so the entry is ready to be
  // registered on the same edge that enters ISSUE.
  codec_cfg_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_rom (
    .idx      (idx_n),
    .sub_addr (rom_addr),
    .data     (rom_data)
  );

  assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

  // Next-state, next-index, retry and sticky-flag decisions.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_n = state;
    idx_n   = index;
    retry_n = retry;
    done_n  = done;
    err_n   = err;
    case (state)
      S_IDLE, S_DONE: begin
        if (start || (state == S_IDLE && AUTO_START)) begin
          state_n = S_ISSUE;
          idx_n   = '0;
          retry_n = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
        end else if (state == S_DONE && vol_pending && !err) begin
          state_n = S_VISSUE;
          retry_n = '0;
        end
      end
      S_ISSUE:  state_n = S_WAIT;
      S_VISSUE: state_n = S_VWAIT;
      S_WAIT, S_VWAIT: begin
        // NewCom takes priority over a timeout landing in the same cycle.
        if (NewCom) begin
          if (state == S_VWAIT || index == IDX_W'(N_ENTRIES - 1)) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_ISSUE;
            idx_n   = index + IDX_W'(1);
            retry_n = '0;
          end
        end else if (timed_out) begin
          if (retry < RTY_W'(MAX_RETRY)) begin
            state_n = (state == S_VWAIT) ? S_VISSUE : S_ISSUE;
            retry_n = retry + RTY_W'(1);
          end else begin
            state_n = S_DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and registered command outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      index       <= '0;
      retry       <= '0;
      timer       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      vol_pending <= 1'b0;
      write       <= 1'b0;
      busy        <= 1'b0;
      SubAddr     <= '0;
      data        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, regardless of statement order.
      state <= state_n;
      index <= idx_n;
      retry <= retry_n;
      done  <= done_n;
      err   <= err_n;
      write <= (state_n == S_ISSUE) || (state_n == S_VISSUE);
      busy  <= (state_n != S_IDLE) && (state_n != S_DONE);

      if (state_n == S_ISSUE || state_n == S_VISSUE) begin
        timer <= '0;
      end else if (state == S_WAIT || state == S_VWAIT) begin
        timer <= timer + TMR_W'(1);
      end

      if (state_n == S_ISSUE) begin
        SubAddr <= rom_addr;
        data    <= rom_data;
      end else if (state_n == S_VISSUE) begin
        SubAddr <= VOL_ADDR;
        data    <= {vol_left, vol_right};
      end

      // Requests collapse into one; a request arriving during VISSUE survives.
      if (vol_req) begin
        vol_pending <= 1'b1;
      end else if (state == S_VISSUE) begin
        vol_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Scoreboard bench for codec_cfg_sequencer: a transaction-level model plans
// each sequence (which attempts the link acknowledges and when), pushes the
// expected strobes, and a monitor compares every strobe as it appears.
module tb_codec_cfg_sequencer;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int MR = 2;
  localparam logic [7:0] VA = 8'h02;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        NewCom = 1'b0;
  logic        vol_req = 1'b0;
  logic [7:0]  vol_left = '0;
  logic [7:0]  vol_right = '0;
  logic [7:0]  SubAddr;
  logic [15:0] data;
  logic        write, busy, done, err;
  logic [1:0]  index;

  always #5 clk = ~clk;

  codec_cfg_sequencer #(
    .ADDR_W(8), .DATA_W(16), .N_ENTRIES(N), .TIMEOUT(TO),
    .MAX_RETRY(MR), .VOL_ADDR(VA), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .NewCom(NewCom),
    .vol_req(vol_req), .vol_left(vol_left), .vol_right(vol_right),
    .SubAddr(SubAddr), .data(data), .write(write), .busy(busy),
    .done(done), .err(err), .index(index)
  );

  // Expected first four entries of the default codec table.
  logic [23:0] tbl [N] = '{24'h0F_0000, 24'h09_0000, 24'h00_0017, 24'h01_0017};

  // gap: cycles since the previous strobe (-1 = unconstrained); idx -1 = don't care
  typedef struct { logic [7:0] addr; logic [15:0] data; int idx; int gap; } exp_t;
  // d: -1 silent, 0 NewCom in the strobe cycle (ignored), >=1 NewCom d cycles later
  typedef struct { int d; bit vp; bit sp; } att_t;

  exp_t exp_q[$];
  att_t att_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   drv_seen = -1;
  int   mon_last = -1;
  bit   pend_m = 1'b0;
  exp_t me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got addr=%h data=%h, required no strobe (cycle %0d)",
                 SubAddr, data, cyc);
      end else begin
        me = exp_q.pop_front();
        check("strobe_addr", 32'(SubAddr), 32'(me.addr));
        check("strobe_data", 32'(data), 32'(me.data));
        if (me.idx >= 0) check("strobe_index", 32'(index), 32'(me.idx));
        if (me.gap >= 0) check("strobe_gap", 32'(cyc - mon_last), 32'(me.gap));
      end
      mon_last = cyc;
    end
  end

  task automatic wait_write(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * TO; i++) begin
      if (write === 1'b1 && cyc != drv_seen) begin
        drv_seen = cyc;
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL strobe_timeout: no strobe within %0d cycles, required one", 4 * TO);
  endtask

  function automatic int pick_d(input int mode, input int e, input int k);
    int r;
    case (mode)
      1: return 8;
      2: return -1;
      3: return (e == 0) ? ((k == 0) ? 0 : 1) : 8;
      default: begin
        r = $urandom_range(0, 99);
        if (r < 72) return $urandom_range(1, TO);
        if (r < 86) return 0;
        return -1;
      end
    endcase
  endfunction

  // Model of one table walk: entries in order, each retried until it is
  // acknowledged or has been attempted MR+1 times.
  task automatic plan_init(input int mode, output bit ab, output int ab_idx);
    int gap, d, k;
    bit vp, sp;
    gap = -1;
    ab = 1'b0;
    ab_idx = 0;
    for (int e = 0; e < N; e++) begin
      k = 0;
      forever begin
        d  = pick_d(mode, e, k);
        vp = (mode == 1) ? (k == 0 && (e == 1 || e == 2))
           : (mode == 0) ? ($urandom_range(0, 99) < 12) : 1'b0;
        sp = (mode == 1) ? (e == 2) : (mode == 0) ? ($urandom_range(0, 99) < 15) : 1'b0;
        exp_q.push_back(exp_t'{tbl[e][23:16], tbl[e][15:0], e, gap});
        att_q.push_back(att_t'{d, vp, sp});
        if (d >= 1) begin
          gap = d + 1;
          break;
        end
        gap = TO + 1;
        k++;
        if (k > MR) begin
          ab = 1'b1;
          ab_idx = e;
          return;
        end
      end
    end
  endtask

  // Acts as the serial link for the planned attempts.
  task automatic run_atts(input bit ab, input int ab_idx, input bit fin);
    att_t a;
    bit ok;
    while (att_q.size() > 0) begin
      a = att_q.pop_front();
      wait_write(ok);
      if (!ok) begin
        att_q.delete();
        exp_q.delete();
        return;
      end
      if (a.vp) pend_m = 1'b1;
      start = a.sp;
      vol_req = a.vp;
      NewCom = (a.d == 0);
      @(negedge clk);
      start = 1'b0;
      vol_req = 1'b0;
      NewCom = 1'b0;
      if (a.d >= 1) begin
        repeat (a.d - 1) @(negedge clk);
        NewCom = 1'b1;
        @(negedge clk);
        NewCom = 1'b0;
      end
      if (fin && att_q.size() == 0) begin
        if (a.d >= 1) begin
          check("end_done", 32'(done), 32'd1);
          check("end_busy", 32'(busy), 32'd0);
          check("end_err", 32'(err), 32'd0);
          check("end_index", 32'(index), 32'(N - 1));
        end else begin
          repeat (TO - 1) @(negedge clk);
          check("pre_abort_busy", 32'(busy), 32'd1);
          check("pre_abort_err", 32'(err), 32'd0);
          @(negedge clk);
          check("abort_err", 32'(err), 32'd1);
          check("abort_done", 32'(done), 32'd1);
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_index", 32'(index), 32'(ab_idx));
        end
      end
    end
  endtask

  task automatic run_vol();
    int gap;
    gap = -1;
    pend_m = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      exp_q.push_back(exp_t'{VA, {vol_left, vol_right}, N - 1, gap});
      att_q.push_back(att_t'{-1, 1'b0, 1'b0});
      gap = TO + 1;
    end
    exp_q.push_back(exp_t'{VA, {vol_left, vol_right}, N - 1, gap});
    att_q.push_back(att_t'{$urandom_range(1, TO), 1'b0, 1'b0});
    run_atts(1'b0, 0, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_done_clr", 32'(done), 32'd0);
    check("start_err_clr", 32'(err), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_index", 32'(index), 32'd0);
  endtask

  // via_start=0: begin by releasing reset (auto-start); 1: pulse start in DONE.
  task automatic run_seq(input int mode, input bit via_start);
    bit ab;
    int ai;
    plan_init(mode, ab, ai);
    if (via_start) pulse_start();
    else reset = 1'b1;
    run_atts(ab, ai, 1'b1);
    if (!ab && pend_m) run_vol();
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #2_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL global_timeout: bench did not complete, required completion");
    summary();
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_write", 32'(write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_subaddr", 32'(SubAddr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_index", 32'(index), 32'd0);

    // Auto-start walk with fixed 8-cycle acks; volume requested mid-init.
    vol_left = 8'h1F;
    vol_right = 8'h0A;
    run_seq(1, 1'b0);

    // Link never answers: entry 0 retried MR times, then abort.
    run_seq(2, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
    vol_left = 8'h33;
    vol_right = 8'h44;
    vol_req = 1'b1;
    pend_m = 1'b1;
    @(negedge clk);
    vol_req = 1'b0;
    repeat (3 * TO) @(negedge clk);
    check("err_hold_busy", 32'(busy), 32'd0);
    check("err_hold_err", 32'(err), 32'd1);

    // Restart after error; NewCom in the strobe cycle is ignored, then one
    // cycle after the retry strobe it is accepted. Pending volume follows.
    run_seq(3, 1'b1);

    for (int it = 0; it < 25; it++) begin
      vol_left = 8'($urandom);
      vol_right = 8'($urandom);
      run_seq(0, 1'b1);
    end

    // Reset while waiting on entry 2; auto-start then restarts at entry 0.
    exp_q.push_back(exp_t'{tbl[0][23:16], tbl[0][15:0], 0, -1});
    exp_q.push_back(exp_t'{tbl[1][23:16], tbl[1][15:0], 1, 9});
    exp_q.push_back(exp_t'{tbl[2][23:16], tbl[2][15:0], 2, 9});
    att_q.push_back(att_t'{8, 1'b0, 1'b0});
    att_q.push_back(att_t'{8, 1'b0, 1'b0});
    pulse_start();
    run_atts(1'b0, 0, 1'b0);
    begin
      bit ok;
      wait_write(ok);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_write", 32'(write), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_subaddr", 32'(SubAddr), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_index", 32'(index), 32'd0);
    pend_m = 1'b0;
    repeat (2) @(negedge clk);
    run_seq(1, 1'b0);

    repeat (2 * TO) @(negedge clk);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
- Parametrised successor to the audio-codec register-set block.
- Walks a table of N_ENTRIES (sub-address, data) pairs. Issues one write pulse per entry and advances only on the serial link's NewCom completion pulse.
- Adds a completion timeout with bounded retry, a sticky error flag, software restart, and a post-init live volume-update command.
- Sits between the codec serial/control-frame engine (which produces NewCom) and the audio loopback top level.

Parameters:
- ADDR_W, 8: sub-address width.
- DATA_W, 16: register data width; must be even.
- N_ENTRIES, 12: init table length, ≥ 1.
- TIMEOUT, 4096: WAIT cycles without NewCom before a retry.
- MAX_RETRY, 3: retries per entry before abort.
- VOL_ADDR, 8'h02: sub-address used for volume updates.
- AUTO_START, 1: 1 = start the sequence automatically after reset release.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request to re-run the init table.
- NewCom, in, 1: one-cycle pulse; the serial link has consumed the current command.
- vol_req, in, 1: one-cycle request to write volume.
- vol_left, in, DATA_W/2: left volume code.
- vol_right, in, DATA_W/2: right volume code.
- SubAddr, out, ADDR_W: command sub-address.
- data, out, DATA_W: command data.
- write, out, 1: one-cycle command strobe.
- busy, out, 1: sequence or volume command in flight.
- done, out, 1: init table completed; sticky.
- err, out, 1: retry budget exhausted; sticky.
- index, out, clog2(N_ENTRIES): current table entry.

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - write, busy, done, err = 0.
  - SubAddr, data, index = 0.
  - Retry and timer counters = 0.
  - vol_pending = 0.
  - Reset asserted mid-operation aborts immediately; no partial write strobe is produced.
- States: IDLE, ISSUE, WAIT, DONE, VISSUE, VWAIT.
- IDLE:
  - AUTO_START=1 → ISSUE on the first clock after reset release.
  - Otherwise waits for start.
- ISSUE (1 cycle):
  - write=1; SubAddr/data = table[index] (registered outputs, valid in the same cycle as write).
  - Timer cleared. → WAIT.
- WAIT: write=0; timer increments each cycle.
  - NewCom=1 and index<N_ENTRIES-1: index+1, retry cleared, → ISSUE.
  - NewCom=1 and index=N_ENTRIES-1: → DONE, done=1.
  - Timer reaches TIMEOUT-1 without NewCom:
    - retry<MAX_RETRY: retry+1, → ISSUE with the same index.
    - Otherwise: err=1, done=1, → DONE.
  - NewCom and timeout in the same cycle: NewCom wins.
- NewCom is sampled only in WAIT/VWAIT. A pulse in any other state (including the ISSUE cycle) is ignored. Earliest accepted NewCom is 1 cycle after write.
- Retry period: TIMEOUT+1 cycles between write strobes.
- busy=1 in ISSUE, WAIT, VISSUE and VWAIT; 0 in IDLE and DONE.
- SubAddr/data hold their last issued value between strobes.
- DONE:
  - start: clears done, err, index and retry; → ISSUE. start in any other state is ignored, except IDLE, where it behaves the same way.
  - Else if vol_pending and err=0: → VISSUE.
- vol_req in any state sets vol_pending. It is served only from DONE, and multiple requests collapse into one.
- VISSUE (1 cycle):
  - write=1; SubAddr=VOL_ADDR; data={vol_left, vol_right}, sampled in this cycle.
  - vol_pending cleared, unless vol_req is high in the same cycle, in which case it stays set.
- VWAIT:
  - Same NewCom and timeout rules as WAIT.
  - Success → DONE.
  - Exhaustion → err=1, → DONE.
- start and vol_pending together in DONE: start wins; vol_pending is kept.

Decomposition:
- Package codec_cfg_pkg holds:
  - State encoding localparams.
  - Default VOL_ADDR.
  - The default init table as a function codec_cfg_entry(idx) returning {addr, data}.
- Sub-module codec_cfg_rom: combinational table lookup, index → {SubAddr, data}. This lets boards swap tables without touching the FSM.

Test Plan:
- Auto-start, N_ENTRIES=4, NewCom 8 cycles after each write → 4 write strobes carrying entries 0..3 in order, index 0→3; done=1 and busy=0 one cycle after the 4th NewCom; err=0.
- TIMEOUT=16, MAX_RETRY=2, NewCom never asserted → 3 strobes on entry 0, 17 cycles apart; err=1, done=1 the cycle after the 3rd timeout.
- NewCom pulsed in the same cycle as write → ignored; next timeout causes a retry; a NewCom one cycle later is accepted and advances.
- vol_req=1 at entry 1 with vol_left=8'h1F, vol_right=8'h0A → no extra strobe during init; after done, one strobe with SubAddr=8'h02, data=16'h1F0A; NewCom → back to DONE with busy=0.
- reset driven low mid-WAIT at entry 2 → all outputs 0 immediately; on release with AUTO_START=1 the sequence restarts from entry 0.
- start pulsed while busy → ignored. start in DONE with err=1 → err and done cleared, entry 0 reissued.
